// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries EX write-back and HI/LO results to MEM and holds the MADD/MSUB partial state.
// Optional EXMEM_PERF_EN adds bubble and useful-advance counters.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
`ifdef EXMEM_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_adv_cnt
`endif
);

  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        whilo_q, whilo_d;
  logic [63:0] hilo_q, hilo_d;
  logic [1:0]  cnt_q, cnt_d;

  logic bubble_s;
  logic advance_s;
  logic unused_stall_s;

  assign unused_stall_s = ^{stall[5], stall[2:0]};
  // stall[3]=0 with stall[4]=1 cannot occur legally and simply advances.
  assign bubble_s  = !flush && stall[3] && !stall[4];
  assign advance_s = !flush && !stall[3];

  // Next-state selection: flush, bubble, advance or hold.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wd_d    = 5'b00000;
      wreg_d  = 1'b0;
      wdata_d = 32'h0000_0000;
      hi_d    = 32'h0000_0000;
      lo_d    = 32'h0000_0000;
      whilo_d = 1'b0;
      hilo_d  = 64'h0000_0000_0000_0000;
      cnt_d   = 2'b00;
    end else if (bubble_s) begin
      // MEM gets a bubble while EX keeps its MADD/MSUB partial result.
      wd_d    = 5'b00000;
      wreg_d  = 1'b0;
      wdata_d = 32'h0000_0000;
      hi_d    = 32'h0000_0000;
      lo_d    = 32'h0000_0000;
      whilo_d = 1'b0;
      hilo_d  = hilo_i;
      cnt_d   = cnt_i;
    end else if (advance_s) begin
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
      hilo_d  = 64'h0000_0000_0000_0000;
      cnt_d   = 2'b00;
    end else begin
      wd_d    = wd_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      whilo_d = whilo_q;
      hilo_d  = hilo_q;
      cnt_d   = cnt_q;
    end
  end

  // Pipeline state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q    <= 5'b00000;
      wreg_q  <= 1'b0;
      wdata_q <= 32'h0000_0000;
      hi_q    <= 32'h0000_0000;
      lo_q    <= 32'h0000_0000;
      whilo_q <= 1'b0;
      hilo_q  <= 64'h0000_0000_0000_0000;
      cnt_q   <= 2'b00;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

`ifdef EXMEM_PERF_EN
  logic [31:0] bub_cnt_q, bub_cnt_d;
  logic [31:0] adv_cnt_q, adv_cnt_d;

  // Counters only move on bubble or write-carrying advance edges; flush leaves them alone.
  always_comb begin
    bub_cnt_d = bub_cnt_q;
    adv_cnt_d = adv_cnt_q;
    if (bubble_s) begin
      bub_cnt_d = bub_cnt_q + 32'd1;
    end else if (advance_s && (ex_wreg || ex_whilo)) begin
      adv_cnt_d = adv_cnt_q + 32'd1;
    end else begin
      bub_cnt_d = bub_cnt_q;
      adv_cnt_d = adv_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bub_cnt_q <= 32'h0000_0000;
      adv_cnt_q <= 32'h0000_0000;
    end else begin
      bub_cnt_q <= bub_cnt_d;
      adv_cnt_q <= adv_cnt_d;
    end
  end

  assign perf_bubble_cnt = bub_cnt_q;
  assign perf_adv_cnt    = adv_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Table-driven bench for ex_mem_reg; each record is one clock edge with the outputs expected after it.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`ifdef EXMEM_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_adv_cnt;
  logic [31:0] exp_bub, exp_adv;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
`ifdef EXMEM_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_adv_cnt(perf_adv_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_whilo;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.flush; stall = v.stall;
    ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata;
    ex_hi = v.hi; ex_lo = v.lo; ex_whilo = v.whilo;
    hilo_i = v.hilo; cnt_i = v.cnt;
  endtask

  task automatic step();
`ifdef EXMEM_PERF_EN
    if (!rst) begin
      exp_bub = 32'd0; exp_adv = 32'd0;
    end else if (!flush && stall[3] && !stall[4]) begin
      exp_bub = exp_bub + 32'd1;
    end else if (!flush && !stall[3] && (ex_wreg || ex_whilo)) begin
      exp_adv = exp_adv + 32'd1;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst   flush stall      wd     wreg  wdata         hi            lo            whilo hilo                    cnt    e_wd   e_wreg e_wdata       e_hi          e_lo          e_whilo e_hilo                  e_cnt
    vecs[0]  = '{1'b0, 1'b0, 6'b000000, 5'd3,  1'b1, 32'h1234_5678, 32'h0000_0001, 32'h0000_0002, 1'b1, 64'h0000_0000_0000_00ff, 2'd2, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 6'b001111, 5'd3,  1'b1, 32'h1234_5678, 32'h0000_0001, 32'h0000_0002, 1'b1, 64'h0000_0000_0000_00ff, 2'd2, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 6'b000000, 5'd3,  1'b1, 32'h1234_5678, 32'h0000_0001, 32'h0000_0002, 1'b1, 64'h0000_0000_0000_00ff, 2'd2, 5'd3,  1'b1, 32'h1234_5678, 32'h0000_0001, 32'h0000_0002, 1'b1, 64'h0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 6'b000000, 5'd5,  1'b1, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0000, 2'd0, 5'd5,  1'b1, 32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 6'b000000, 5'd7,  1'b0, 32'h2222_2222, 32'h0000_aaaa, 32'h0000_bbbb, 1'b1, 64'h0000_0000_0000_0003, 2'd1, 5'd7,  1'b0, 32'h2222_2222, 32'h0000_aaaa, 32'h0000_bbbb, 1'b1, 64'h0, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 6'b000000, 5'd31, 1'b1, 32'hffff_ffff, 32'h0000_0000, 32'hffff_ffff, 1'b0, 64'h0000_0000_0000_0000, 2'd0, 5'd31, 1'b1, 32'hffff_ffff, 32'h0000_0000, 32'hffff_ffff, 1'b0, 64'h0, 2'd0};
    vecs[6]  = '{1'b1, 1'b0, 6'b001111, 5'd9,  1'b1, 32'h3333_3333, 32'h0000_0004, 32'h0000_0005, 1'b1, 64'hDEAD_BEEF_0000_0001, 2'd1, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'hDEAD_BEEF_0000_0001, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 6'b000000, 5'd2,  1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0005, 2'd3, 5'd2,  1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000, 1'b1, 64'h0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 6'b011111, 5'd4,  1'b0, 32'hDEAD_0001, 32'h0000_0009, 32'h0000_0009, 1'b0, 64'h0000_0000_0000_0077, 2'd2, 5'd2,  1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000, 1'b1, 64'h0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 6'b011111, 5'd8,  1'b1, 32'hDEAD_0002, 32'h0000_0008, 32'h0000_0007, 1'b0, 64'h0000_0000_0000_0088, 2'd1, 5'd2,  1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000, 1'b1, 64'h0, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 6'b011111, 5'd16, 1'b0, 32'hDEAD_0003, 32'h0000_0006, 32'h0000_0005, 1'b1, 64'h0000_0000_0000_0099, 2'd3, 5'd2,  1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000, 1'b1, 64'h0, 2'd0};
    vecs[11] = '{1'b1, 1'b1, 6'b011111, 5'd12, 1'b1, 32'h4444_4444, 32'h0000_0001, 32'h0000_0001, 1'b1, 64'h0000_0000_0000_0011, 2'd1, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0, 2'd0};
    vecs[12] = '{1'b1, 1'b0, 6'b001111, 5'd12, 1'b1, 32'h5555_5555, 32'h0000_0001, 32'h0000_0001, 1'b1, 64'h0123_4567_89AB_CDEF, 2'd1, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd1};
    vecs[13] = '{1'b1, 1'b0, 6'b011111, 5'd13, 1'b1, 32'h6666_0000, 32'h0000_0002, 32'h0000_0002, 1'b0, 64'h0000_0000_0000_0000, 2'd2, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd1};
    vecs[14] = '{1'b1, 1'b0, 6'b001111, 5'd13, 1'b1, 32'h6666_0001, 32'h0000_0002, 32'h0000_0002, 1'b0, 64'h0000_0000_0000_0010, 2'd2, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0010, 2'd2};
    vecs[15] = '{1'b0, 1'b0, 6'b011111, 5'd14, 1'b1, 32'h7777_7777, 32'h0000_0003, 32'h0000_0003, 1'b1, 64'h0000_0000_0000_0020, 2'd3, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0, 2'd0};
    vecs[16] = '{1'b1, 1'b0, 6'b010000, 5'd6,  1'b1, 32'h6666_6666, 32'h0000_0001, 32'h0000_0001, 1'b0, 64'h0000_0000_0000_0009, 2'd1, 5'd6,  1'b1, 32'h6666_6666, 32'h0000_0001, 32'h0000_0001, 1'b0, 64'h0, 2'd0};
    vecs[17] = '{1'b1, 1'b1, 6'b001111, 5'd6,  1'b1, 32'h8888_8888, 32'h0000_0001, 32'h0000_0001, 1'b1, 64'h0000_0000_0000_0005, 2'd1, 5'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0, 2'd0};

`ifdef EXMEM_PERF_EN
    exp_bub = 32'd0; exp_adv = 32'd0;
`endif
    drive(vecs[0]);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      check("mem_wd",    i, {59'd0, mem_wd},    {59'd0, vecs[i].e_wd});
      check("mem_wreg",  i, {63'd0, mem_wreg},  {63'd0, vecs[i].e_wreg});
      check("mem_wdata", i, {32'd0, mem_wdata}, {32'd0, vecs[i].e_wdata});
      check("mem_hi",    i, {32'd0, mem_hi},    {32'd0, vecs[i].e_hi});
      check("mem_lo",    i, {32'd0, mem_lo},    {32'd0, vecs[i].e_lo});
      check("mem_whilo", i, {63'd0, mem_whilo}, {63'd0, vecs[i].e_whilo});
      check("hilo_o",    i, hilo_o,             vecs[i].e_hilo);
      check("cnt_o",     i, {62'd0, cnt_o},     {62'd0, vecs[i].e_cnt});
`ifdef EXMEM_PERF_EN
      check("perf_bubble_cnt", i, {32'd0, perf_bubble_cnt}, {32'd0, exp_bub});
      check("perf_adv_cnt",    i, {32'd0, perf_adv_cnt},    {32'd0, exp_adv});
`endif
    end

    // Partial product captured by a bubble must survive a long MEM stall with changing inputs.
    rst = 1'b1; flush = 1'b0; stall = 6'b001111;
    hilo_i = 64'hCAFE_F00D_1234_0001; cnt_i = 2'd1;
    step();
    check("seq_bubble_hilo", 100, hilo_o, 64'hCAFE_F00D_1234_0001);
    for (int k = 0; k < 4; k++) begin
      stall = 6'b011111;
      hilo_i = {$urandom(), $urandom()};
      cnt_i = 2'($urandom_range(0, 3));
      ex_wdata = $urandom();
      step();
      check("seq_hold_hilo", 101 + k, hilo_o, 64'hCAFE_F00D_1234_0001);
      check("seq_hold_cnt",  101 + k, {62'd0, cnt_o}, {62'd1, 2'd1} & 64'h3);
      check("seq_hold_wreg", 101 + k, {63'd0, mem_wreg}, 64'd0);
    end

`ifdef EXMEM_PERF_EN
    // Four bubbles then two writing advances from a fresh reset; flush must not touch the counters.
    rst = 1'b0; stall = 6'b000000; step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin stall = 6'b001111; step(); end
    for (int k = 0; k < 2; k++) begin stall = 6'b000000; ex_wreg = 1'b1; ex_whilo = 1'b0; step(); end
    check("perf_bubble_4", 200, {32'd0, perf_bubble_cnt}, 64'd4);
    check("perf_adv_2",    200, {32'd0, perf_adv_cnt},    64'd2);
    flush = 1'b1; step(); flush = 1'b0;
    check("perf_bubble_flush", 201, {32'd0, perf_bubble_cnt}, 64'd4);
    check("perf_adv_flush",    201, {32'd0, perf_adv_cnt},    64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage.
- Each cycle it captures EX results: register write-back, HI/LO write-back, and the multi-cycle MADD/MSUB accumulation state.
- It presents those values to the MEM stage one cycle later.
- It obeys the global stall vector and flush, and inserts bubbles when EX stalls but MEM does not.

Parameters:
- None. Widths come from the shared define file: RegBus = 32, RegAddrBus = 5, DoubleRegBus = 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising clk edge
- stall  input  6  global stall vector; bit 3 = EX stalled, bit 4 = MEM stalled
- flush  input  1  pipeline flush (exception); active-high
- ex_wd  input  5  EX destination register address
- ex_wreg  input  1  EX register write enable
- ex_wdata  input  32  EX register write data
- ex_hi  input  32  EX HI write value
- ex_lo  input  32  EX LO write value
- ex_whilo  input  1  EX HI/LO write enable
- hilo_i  input  64  EX MADD/MSUB partial product for the current cycle
- cnt_i  input  2  EX MADD/MSUB cycle count for the current cycle
- mem_wd  output  5  registered destination address to MEM
- mem_wreg  output  1  registered write enable to MEM
- mem_wdata  output  32  registered write data to MEM
- mem_hi  output  32  registered HI value to MEM
- mem_lo  output  32  registered LO value to MEM
- mem_whilo  output  1  registered HI/LO write enable to MEM
- hilo_o  output  64  held partial product, fed back to EX
- cnt_o  output  2  held cycle count, fed back to EX

Behaviour:
- All outputs are registered and change only on a rising clk edge; latency is one cycle from EX to MEM.
- Priority per edge, highest first:
  1. rst == 0: all outputs to 0 (mem_wd = NOPRegAddr = 5'b00000; enables = WriteDisable).
  2. flush == 1: same values as reset. The flush overrides any stall.
  3. stall[3] == 1 and stall[4] == 0: bubble into MEM.
     - mem_* outputs all 0.
     - hilo_o <= hilo_i and cnt_o <= cnt_i, so EX can complete its second MADD/MSUB cycle.
  4. stall[3] == 0: normal advance.
     - mem_* <= ex_* (mem_wd <= ex_wd, mem_wreg <= ex_wreg, mem_wdata <= ex_wdata, mem_hi <= ex_hi, mem_lo <= ex_lo, mem_whilo <= ex_whilo).
     - hilo_o <= 0 and cnt_o <= 0.
  5. stall[3] == 1 and stall[4] == 1: hold every output, including hilo_o and cnt_o.
- stall[3] == 0 with stall[4] == 1 is illegal, because the stall vector is monotone. The block treats it as case 4 and does not need to detect it.
- Reset or flush mid-MADD (cnt_o != 0): hilo_o and cnt_o clear, and the accumulation is abandoned.
- No combinational path from any input to any output.

Optional Feature:
- Macro EXMEM_PERF_EN.
- Defined: adds two outputs.
  - perf_bubble_cnt (32 bits): +1 on every case-3 edge.
  - perf_adv_cnt (32 bits): +1 on every case-4 edge where ex_wreg or ex_whilo is 1.
  - Both cleared by rst == 0; unaffected by flush; wrap modulo 2^32; hold in case 5.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset: rst = 0 for 2 cycles with nonzero inputs -> all outputs 0; release rst -> the next edge shows ex_wd = 5'd3, ex_wreg = 1, ex_wdata = 32'h1234_5678 at mem_*.
2. Advance: three back-to-back instructions -> each appears on mem_* exactly one edge later, with hilo_o = 0 and cnt_o = 0.
3. Bubble: stall = 6'b001111 with ex_wreg = 1, hilo_i = 64'hDEAD_BEEF_0000_0001, cnt_i = 1 -> next edge gives mem_wreg = 0, mem_wdata = 0, hilo_o = 64'hDEAD_BEEF_0000_0001, cnt_o = 1.
4. Hold: load mem_wdata = 32'hA5A5_A5A5, then stall = 6'b011111 for 3 cycles while the inputs change -> mem_wdata stays 32'hA5A5_A5A5 and hilo_o/cnt_o are unchanged.
5. Flush: flush = 1 together with stall = 6'b011111 and mem_whilo = 1 -> next edge gives all outputs 0.
6. EXMEM_PERF_EN: 4 bubble edges, then 2 advancing edges with a write enable -> perf_bubble_cnt = 4, perf_adv_cnt = 2; a flush leaves both unchanged.
